// File: rtl/accelerator_pkg.sv
// Shared types for the OBI data-port arbiter: requester identity and arbiter FSM state.
package accelerator_pkg;

    typedef enum logic {
        OBI_OWNER_CORE = 1'b0,
        OBI_OWNER_VLSU = 1'b1
    } obi_owner_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic obi_owner_e other_owner(input obi_owner_e owner);
        return (owner == OBI_OWNER_CORE) ? OBI_OWNER_VLSU : OBI_OWNER_CORE;
    endfunction

endpackage

// File: rtl/obi_owner_fifo.sv
// FIFO of requester identities, one entry per granted-but-unanswered OBI transaction.
// A push while full is accepted only together with a pop.
module obi_owner_fifo
    import accelerator_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic n_reset,
    input  logic push,
    input  logic push_owner,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_owner;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one OBI data master between the core LSU and the vector LSU; responses are routed by an owner FIFO.
// Build option: define OBI_ARB_RR_EN for round-robin arbitration, otherwise the core has fixed priority.
module obi_mem_arbiter
    import accelerator_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        core_req_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    input  logic [31:0] core_addr_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] core_rdata_o,
    input  logic        vlsu_req_i,
    output logic        vlsu_gnt_o,
    output logic        vlsu_rvalid_o,
    input  logic [31:0] vlsu_addr_i,
    input  logic        vlsu_we_i,
    input  logic [3:0]  vlsu_be_i,
    input  logic [31:0] vlsu_wdata_i,
    output logic [31:0] vlsu_rdata_o,
    input  logic        vlsu_lock_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic        arb_state_o
);

    arb_state_e state, state_n;
    obi_owner_e hold_owner, hold_owner_n;
    obi_owner_e sel;
    logic       sel_valid;
    logic       core_cand;
    logic       fire;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       sel_core;

`ifdef OBI_ARB_RR_EN
    obi_owner_e rr_ptr;
`endif

    // HOLD keeps the pending owner on the bus until granted (OBI stability); a full FIFO blocks new picks.
    always_comb begin
        core_cand    = core_req_i & ~vlsu_lock_i;
        state_n      = state;
        hold_owner_n = hold_owner;
        sel          = OBI_OWNER_CORE;
        sel_valid    = 1'b0;
        if (state == ARB_HOLD) begin
            sel       = hold_owner;
            sel_valid = (hold_owner == OBI_OWNER_CORE) ? core_req_i : vlsu_req_i;
            if (data_gnt_i || !sel_valid) begin
                state_n = ARB_IDLE;
            end
        end else if (!fifo_full) begin
            if (core_cand) begin
                sel       = OBI_OWNER_CORE;
                sel_valid = 1'b1;
            end else if (vlsu_req_i) begin
                sel       = OBI_OWNER_VLSU;
                sel_valid = 1'b1;
            end
`ifdef OBI_ARB_RR_EN
            if (core_cand && vlsu_req_i) begin
                sel = rr_ptr;
            end
`endif
            if (sel_valid && !data_gnt_i) begin
                state_n      = ARB_HOLD;
                hold_owner_n = sel;
            end
        end
    end

    assign sel_core     = (sel == OBI_OWNER_CORE);
    assign data_req_o   = sel_valid;
    assign data_addr_o  = !sel_valid ? '0 : (sel_core ? core_addr_i  : vlsu_addr_i);
    assign data_we_o    = sel_valid & (sel_core ? core_we_i : vlsu_we_i);
    assign data_be_o    = !sel_valid ? '0 : (sel_core ? core_be_i    : vlsu_be_i);
    assign data_wdata_o = !sel_valid ? '0 : (sel_core ? core_wdata_i : vlsu_wdata_i);

    assign fire       = sel_valid & data_gnt_i;
    assign core_gnt_o = fire & sel_core;
    assign vlsu_gnt_o = fire & ~sel_core;

    // A response with nothing outstanding is dropped rather than routed.
    assign pop           = data_rvalid_i & ~fifo_empty;
    assign core_rvalid_o = pop & (fifo_head == OBI_OWNER_CORE);
    assign vlsu_rvalid_o = pop & (fifo_head == OBI_OWNER_VLSU);
    assign core_rdata_o  = data_rdata_i;
    assign vlsu_rdata_o  = data_rdata_i;
    assign arb_state_o   = state;

    obi_owner_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_owner_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (fire),
        .push_owner(sel),
        .pop       (data_rvalid_i),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= ARB_IDLE;
            hold_owner <= OBI_OWNER_CORE;
        end else begin
            state      <= state_n;
            hold_owner <= hold_owner_n;
        end
    end

`ifdef OBI_ARB_RR_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rr_ptr <= OBI_OWNER_CORE;
        end else if (fire) begin
            rr_ptr <= other_owner(sel);
        end
    end
`endif

    unexpected_rvalid: assert property (@(posedge clk) disable iff (!n_reset)
        !(data_rvalid_i && fifo_empty))
        else $warning("data_rvalid_i with no outstanding transaction, response dropped");

endmodule
